dec_lut_decoder12_clk: RTL and testbench

//  Sequential 12-bit index decoder. Maps a 25-bit code word W to index N, the largest
//  k in [0,4095] with T(k) <= W, where T(k) = k*(k+1)/2 (triangular threshold LUT).

---
 rtl/dec_lut_decoder12_clk.sv | 129 ++++++++++++
 tb/tb_dec_lut_decoder12_clk.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dec_lut_decoder12_clk.sv
// Clocked triangular-threshold decoder: N = largest k with k*(k+1)/2 <= W, via a 12-step binary search.
// Optional range flag on N[12] enabled by defining DEC_LUT_RANGE_FLAG_EN.
module dec_lut_decoder12_clk #(
  parameter int W_BITS = 25,
  parameter int N_BITS = 13,
  parameter int K_BITS = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_BITS-1:0] W,
  output logic              found,
  output logic [N_BITS-1:0] N
);

  localparam int PTR_W = $clog2(K_BITS);
  localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(K_BITS - 1);
  localparam logic [W_BITS-1:0] T_LIMIT =
      W_BITS'(((2 ** K_BITS) * (2 ** K_BITS + 1)) / 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [W_BITS-1:0]  w_q;
  logic [K_BITS-1:0]  result;
  logic [PTR_W-1:0]   bit_ptr;

  logic [K_BITS-1:0]  cand;
  logic [W_BITS-1:0]  cand_ext;
  logic [W_BITS-1:0]  prod;
  logic [W_BITS-1:0]  thr;
  logic               hit;
  logic               w_changed;
  logic               range_flag;

  logic               capture;
  logic               step;
  logic               load_n;
  logic               restart;

  // Trial index for this step: current partial result with the probed bit set.
  always_comb begin
    cand     = result | (K_BITS'(1) << bit_ptr);
    cand_ext = W_BITS'(cand);
    prod     = cand_ext * (cand_ext + W_BITS'(1));
    thr      = prod >> 1;
    hit      = (thr <= w_q);
  end

  assign w_changed = (W != w_q);

`ifdef DEC_LUT_RANGE_FLAG_EN
  assign range_flag = (w_q >= T_LIMIT);
`else
  assign range_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = SEARCH;
      SEARCH:  state_nxt = (bit_ptr == '0) ? DONE : SEARCH;
      DONE:    state_nxt = (found && w_changed) ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first DONE cycle (found still low) is the load cycle; afterwards DONE only watches W.
  always_comb begin
    capture = 1'b0;
    step    = 1'b0;
    load_n  = 1'b0;
    restart = 1'b0;
    case (state)
      IDLE:    capture = 1'b1;
      SEARCH:  step    = 1'b1;
      DONE: begin
        load_n  = !found;
        restart = found && w_changed;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q     <= '0;
      result  <= '0;
      bit_ptr <= PTR_TOP;
      found   <= 1'b0;
      N       <= '0;
    end else begin
      if (capture) begin
        w_q     <= W;
        result  <= '0;
        bit_ptr <= PTR_TOP;
        found   <= 1'b0;
      end
      if (step) begin
        if (hit) begin
          result <= cand;
        end
        if (bit_ptr != '0) begin
          bit_ptr <= bit_ptr - PTR_W'(1);
        end
      end
      if (load_n) begin
        N     <= {range_flag, result};
        found <= 1'b1;
      end
      if (restart) begin
        found <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dec_lut_decoder12_clk.sv
// Scoreboard bench for dec_lut_decoder12_clk: driver queues expected {N, completion cycle}, monitor checks each found rise.
module tb_dec_lut_decoder12_clk;

  logic        clk;
  logic        rst_n;
  logic [24:0] W;
  logic        found;
  logic [12:0] N;

  dec_lut_decoder12_clk dut (
    .clk   (clk),
    .rst_n (rst_n),
    .W     (W),
    .found (found),
    .N     (N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] w;
    logic [12:0] n;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [24:0] cur_w;
  logic        prev_found = 1'b0;
  logic [12:0] held_n = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Largest k with k(k+1)/2 <= w, from the closed-form root, capped at the table end.
  function automatic logic [12:0] ref_n(input logic [24:0] w);
    longint k;
    longint wl;
    logic   flag;
    wl = longint'(w);
    k  = longint'($rtoi(($sqrt(8.0 * real'(wl) + 1.0) - 1.0) / 2.0));
    while (k > 0 && (k * (k + 1)) / 2 > wl) k--;
    while (((k + 1) * (k + 2)) / 2 <= wl) k++;
    if (k > 4095) k = 4095;
`ifdef DEC_LUT_RANGE_FLAG_EN
    flag = (wl >= 64'd8390656);
`else
    flag = 1'b0;
`endif
    return {flag, 12'(k)};
  endfunction

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every found rise must match the oldest pending expectation, N stays put while found holds.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (found === 1'b1 && prev_found !== 1'b1) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_found: N=%0d with no pending vector (cycle %0d)", N, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check($sformatf("N_w%0d", e.w), 25'(N), 25'(e.n));
          check($sformatf("latency_w%0d", e.w), 25'(cyc), 25'(e.cyc));
        end
        held_n = N;
      end else if (found === 1'b1) begin
        check("N_stable", 25'(N), 25'(held_n));
      end
    end
    prev_found = found;
  end

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(q.size() == 0 && found === 1'b1) && n < 40);
    if (!(q.size() == 0 && found === 1'b1)) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: found=%b pending=%0d after %0d cycles", found, q.size(), n);
      q.delete();
    end
  endtask

  // Change W while DONE holds a result; found must drop on the next edge.
  task automatic apply(input logic [24:0] w);
    exp_t e;
    wait_done();
    if (w == cur_w) w = w ^ 25'd1;
    W     = w;
    cur_w = w;
    e.w   = w;
    e.n   = ref_n(w);
    e.cyc = cyc + 15;
    q.push_back(e);
    @(negedge clk); #1;
    check("found_drop", 25'(found), 25'd0);
  endtask

  initial begin
    logic [24:0] small_w [5];
    exp_t        e;
    logic [24:0] rw;
    small_w = '{25'd0, 25'd1, 25'd2, 25'd3, 25'd6};

    rst_n = 1'b0;
    W     = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_found", 25'(found), 25'd0);
    check("reset_N", 25'(N), 25'd0);

    W     = 25'd8386560;
    cur_w = W;
    rst_n = 1'b1;
    e.w   = W;
    e.n   = ref_n(W);
    e.cyc = cyc + 14;
    q.push_back(e);

    apply(25'd8390655);
    foreach (small_w[i]) apply(small_w[i]);
    apply(25'd8390656);

    wait_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      check("hold_found", 25'(found), 25'd1);
    end

    // Reset for one edge in the middle of a search, then let the same W complete afresh.
    apply(25'd12345);
    repeat (4) @(negedge clk);
    #1;
    void'(q.pop_back());
    rst_n = 1'b0;
    e.cyc = cyc + 15;
    @(negedge clk); #1;
    check("midreset_found", 25'(found), 25'd0);
    check("midreset_N", 25'(N), 25'd0);
    rst_n = 1'b1;
    e.w   = cur_w;
    e.n   = ref_n(cur_w);
    q.push_back(e);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0:       rw = 25'($urandom_range(0, 200));
        1:       rw = 25'($urandom_range(8380000, 8395000));
        default: rw = 25'($urandom);
      endcase
      apply(rw);
    end

    for (int v = 8386560; v <= 8390655; v += 16) apply(25'(v));
    apply(25'd8390655);

    wait_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
